// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Types and constants shared by the instruction fetch unit and its watchdog:
//   FSM state encoding, fetch_err codes and the NOP substitute instruction.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef logic [1:0] fetch_err_t;

  localparam fetch_err_t FETCH_OK       = 2'b00;
  localparam fetch_err_t FETCH_MISALIGN = 2'b01;
  localparam fetch_err_t FETCH_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fetch_timeout_ctr
//   Memory-ack watchdog. Counts enabled cycles since the last clear and flags
//   expire while the count equals LIMIT-1.
//
//   Parameters : LIMIT  - number of counted cycles before expiry (>= 2)
//   Ports      : clk, reset_n (async, active-low)
//                clr    - restart the count from zero (wins over en)
//                en     - advance the count by one
//                expire - count has reached LIMIT-1
// -----------------------------------------------------------------------------
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CTR_W = $clog2(LIMIT);
  localparam logic [CTR_W-1:0] LAST = CTR_W'(LIMIT - 1);

  logic [CTR_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != LAST)) begin
      // Saturate at LAST so the flag cannot wrap back to zero unnoticed.
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = (count_q == LAST);

endmodule : fetch_timeout_ctr

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Takes a fetch address from the PC stage, reads one instruction word from
//   instruction memory over a req/ack bus and hands it to decode with a
//   valid/ready handshake. Misaligned addresses are answered with a NOP and
//   fetch_err=01 without touching memory.
//
//   Optional feature: define FETCH_TIMEOUT_EN to compile in a memory-ack
//   watchdog; after TIMEOUT_CYC request cycles without ack the request is
//   dropped and a NOP is returned with fetch_err=10.
//
//   Parameters : N_BIT (address/instruction width), TIMEOUT_CYC (watchdog)
//   Ports      : clk, reset_n (async, active-low)
//                pc_in/pc_valid/pc_ready        - fetch address from PC stage
//                mem_req/mem_addr/mem_ack/mem_rdata - instruction memory bus
//                instr/instr_pc/fetch_err/instr_valid/instr_ready - to decode
//   All outputs are registered except pc_ready, which is decoded from state.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned N_BIT       = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BIT-1:0] pc_in,
  input  logic             pc_valid,
  output logic             pc_ready,
  output logic             mem_req,
  output logic [N_BIT-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [N_BIT-1:0] mem_rdata,
  output logic [N_BIT-1:0] instr,
  output logic [N_BIT-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [1:0]       fetch_err
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cfg
    $error("instr_fetch_unit: TIMEOUT_CYC must be at least 2");
  end

  fetch_state_t state_q, state_d;
  logic         accept;
  logic         aligned;
  logic         timeout_hit;

  assign accept  = (state_q == IDLE) && pc_valid;
  assign aligned = (pc_in[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
  logic wd_expire;

  fetch_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      ((state_q == REQ) && !mem_ack),
    .expire  (wd_expire)
  );

  // An ack in the terminal cycle takes priority over the timeout.
  assign timeout_hit = (state_q == REQ) && wd_expire && !mem_ack;
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: state lives in always_ff with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_ready = 1'b1;
        if (pc_valid) state_d = aligned ? REQ : HOLD;
      end
      REQ:     if (mem_ack || timeout_hit) state_d = HOLD;
      HOLD:    if (instr_ready)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs. instr/instr_pc/fetch_err are left untouched after
  // the decode handshake; only instr_valid qualifies them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= FETCH_OK;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pc_valid) begin
            instr_pc <= pc_in;
            if (aligned) begin
              mem_req  <= 1'b1;
              mem_addr <= pc_in;
            end else begin
              instr       <= N_BIT'(NOP_INSTR);
              fetch_err   <= FETCH_MISALIGN;
              instr_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            instr       <= mem_rdata;
            fetch_err   <= FETCH_OK;
            instr_valid <= 1'b1;
          end else if (timeout_hit) begin
            mem_req     <= 1'b0;
            instr       <= N_BIT'(NOP_INSTR);
            fetch_err   <= FETCH_TIMEOUT;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) instr_valid <= 1'b0;
        end
        default: begin
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : instr_fetch_unit
